pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Pipeline hazard and advance controller for the 5-stage MIPS core. It drives the control signals every pipeline latch consumes: stall, flush, hit_check and hit_check2. Each latch updates only when hit_check && !hit_check2, and loads a bubble when stall or flush is also high. The block detects load-use hazards and control-flow flushes, sequences data-cache waits and halt, and keeps saturating performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  icache hit for the current fetch.
- dhit  in  1  dcache hit or ack for the MEM-stage access.
- IF_rs  in  5  rs field of the instruction in the IF/ID latch.
- IF_rt  in  5  rt field of the instruction in the IF/ID latch.
- IF_uses_rt  in  1  that instruction reads rt as a source.
- ID_mem2reg  in  1  ID/EX latch holds a load.
- ID_RegWen  in  1  ID/EX latch writes a register.
- ID_wsel  in  5  resolved destination register of the ID/EX instruction.
- EX_flush_req  in  1  taken branch or jump resolved in EX.
- MEM_dREN  in  1  EX/MEM latch holds a load.
- MEM_dWEN  in  1  EX/MEM latch holds a store.
- MEM_halt  in  1  EX/MEM latch holds HALT.
- stall  out  1  load-use bubble request.
- flush  out  1  squash IF/ID and ID/EX.
- hit_check  out  1  pipeline may advance this cycle.
- hit_check2  out  1  pipeline frozen by the halt hold.
- pc_en  out  1  PC register update enable.
- iREN_en  out  1  gate on the icache read request.
- halted  out  1  core halted.
- stall_cnt  out  CNT_W  counted stall advances.
- flush_cnt  out  CNT_W  counted flush advances.
- wait_cnt  out  CNT_W  counted cycles with no advance.

## Operation
- Data op: dop = MEM_dREN | MEM_dWEN.
- FSM states:
  - RUN: if dop && !dhit, go to DWAIT. Else if MEM_halt && hit_check, go to HALT.
  - DWAIT: stay until dhit, then return to RUN.
  - HALT: absorbing; leaves only on reset.
- hit_check:
  - RUN: dop ? dhit : ihit.
  - DWAIT: dhit.
  - HALT: 0.
- hit_check2 = (state == HALT). halted = hit_check2.
- iREN_en = (state == RUN) && !dop. The icache is not requested while a data access is pending.
- Load-use hazard: haz = ID_mem2reg && ID_RegWen && ID_wsel != 0 && (ID_wsel == IF_rs || (IF_uses_rt && ID_wsel == IF_rt)).
- flush = EX_flush_req && hit_check.
- stall = haz && hit_check && !flush. Flush has priority over stall.
- pc_en = hit_check && !hit_check2 && !stall. On a flush cycle the PC loads the branch or jump target.
- Register 0 never causes a hazard.

Counters (saturating at all-ones, never wrapping):
- stall_cnt increments when stall && pc_adv, where pc_adv = hit_check && !hit_check2.
- flush_cnt increments when flush && pc_adv.
- wait_cnt increments when hit_check == 0 && state != HALT.

## Timing
- stall, flush, hit_check, hit_check2, pc_en and iREN_en are combinational from the inputs and the registered state. There is no added latency.
- The FSM state and all counters are registered on the CLK rising edge.
- Reset values: state RUN, all counters 0, halted 0, hit_check2 0.
- During reset, the combinational outputs follow the RUN equations.
- Reset asserted mid-DWAIT or in HALT returns to RUN immediately (asynchronous). Counters clear at the same time.
- DWAIT exit: the dhit cycle is itself an advance cycle. hit_check = 1 in that same cycle, and the state is back in RUN on the next edge.
- Load-use stall lasts exactly one advance. After that edge the load has moved to EX and ID_mem2reg then describes the bubble (0).
- dhit together with MEM_halt in RUN: advance once, then enter HALT.
- EX_flush_req during a cycle with hit_check = 0 is ignored until the first cycle with hit_check = 1. The EX latch holds its request until then.

## Test plan
- Load-use hazard:
  - Stimulus: ID_mem2reg=1, ID_RegWen=1, ID_wsel=8, IF_rs=8, ihit=1, no dop.
  - Response: stall=1, pc_en=0, stall_cnt 0→1. Same stimulus with ID_wsel=0: stall=0, pc_en=1.
- Flush beats stall:
  - Stimulus: the hazard above plus EX_flush_req=1.
  - Response: flush=1, stall=0, pc_en=1, flush_cnt +1, stall_cnt unchanged.
- Data wait:
  - Stimulus: MEM_dREN=1, dhit=0 for 3 cycles, then 1.
  - Response: DWAIT for 3 cycles with hit_check=0 and iREN_en=0, wait_cnt=3. hit_check=1 on the dhit cycle, state RUN after it.
- Halt:
  - Stimulus: MEM_halt=1, ihit=1.
  - Response: after the edge, halted=1, hit_check2=1, pc_en=0. This persists with arbitrary inputs over 10 cycles.
- Reset mid-DWAIT:
  - Stimulus: nRST low during DWAIT.
  - Response: state RUN and all counters 0 immediately, without waiting for a clock edge.
- Saturation:
  - Stimulus: preload/force stall_cnt=16'hFFFF, then a further stall advance.
  - Response: stall_cnt stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline advance/hazard controller for the 5-stage core: load-use stalls,
// control-flow flushes, dcache wait and halt sequencing, saturating perf counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal flow; advance on ihit (or dhit when a data op is in MEM)
// DWAIT | dcache access outstanding; advance only on dhit
// HALT  | HALT retired from MEM; pipeline frozen until reset
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       IF_rs,
    input  logic [4:0]       IF_rt,
    input  logic             IF_uses_rt,
    input  logic             ID_mem2reg,
    input  logic             ID_RegWen,
    input  logic [4:0]       ID_wsel,
    input  logic             EX_flush_req,
    input  logic             MEM_dREN,
    input  logic             MEM_dWEN,
    input  logic             MEM_halt,
    output logic             stall,
    output logic             flush,
    output logic             hit_check,
    output logic             hit_check2,
    output logic             pc_en,
    output logic             iREN_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic dop;
    logic haz;
    logic pc_adv;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign dop = MEM_dREN | MEM_dWEN;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign haz = ID_mem2reg && ID_RegWen && (ID_wsel != 5'd0) &&
                 ((ID_wsel == IF_rs) || (IF_uses_rt && (ID_wsel == IF_rt)));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (dop && !dhit) begin
                    state_d = S_DWAIT;
                end else if (MEM_halt && hit_check) begin
                    state_d = S_HALT;
                end
            end
            S_DWAIT: begin
                if (dhit) begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        hit_check  = 1'b0;
        hit_check2 = 1'b0;
        iREN_en    = 1'b0;
        case (state_q)
            S_RUN: begin
                hit_check = dop ? dhit : ihit;
                iREN_en   = !dop;
            end
            S_DWAIT: begin
                hit_check = dhit;
            end
            S_HALT: begin
                hit_check2 = 1'b1;
            end
            default: begin
                hit_check = 1'b0;
            end
        endcase

        // A flush squashes the dependent instruction, so it takes priority over stall.
        flush  = EX_flush_req && hit_check;
        stall  = haz && hit_check && !flush;
        pc_adv = hit_check && !hit_check2;
        pc_en  = pc_adv && !stall;
        halted = hit_check2;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (stall && pc_adv) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
        if (flush && pc_adv) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end
        if (!hit_check && (state_q != S_HALT)) begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazards, flush priority, dcache wait,
// halt hold, asynchronous reset and counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ihit;
    logic        dhit;
    logic [4:0]  IF_rs;
    logic [4:0]  IF_rt;
    logic        IF_uses_rt;
    logic        ID_mem2reg;
    logic        ID_RegWen;
    logic [4:0]  ID_wsel;
    logic        EX_flush_req;
    logic        MEM_dREN;
    logic        MEM_dWEN;
    logic        MEM_halt;
    logic        stall;
    logic        flush;
    logic        hit_check;
    logic        hit_check2;
    logic        pc_en;
    logic        iREN_en;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [15:0] wait_cnt;

    int checks;
    int failures;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .dhit         (dhit),
        .IF_rs        (IF_rs),
        .IF_rt        (IF_rt),
        .IF_uses_rt   (IF_uses_rt),
        .ID_mem2reg   (ID_mem2reg),
        .ID_RegWen    (ID_RegWen),
        .ID_wsel      (ID_wsel),
        .EX_flush_req (EX_flush_req),
        .MEM_dREN     (MEM_dREN),
        .MEM_dWEN     (MEM_dWEN),
        .MEM_halt     (MEM_halt),
        .stall        (stall),
        .flush        (flush),
        .hit_check    (hit_check),
        .hit_check2   (hit_check2),
        .pc_en        (pc_en),
        .iREN_en      (iREN_en),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wait_cnt     (wait_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0;
        IF_rs = 5'd0; IF_rt = 5'd0; IF_uses_rt = 1'b0;
        ID_mem2reg = 1'b0; ID_RegWen = 1'b0; ID_wsel = 5'd0;
        EX_flush_req = 1'b0; MEM_dREN = 1'b0; MEM_dWEN = 1'b0; MEM_halt = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] wsel);
        ID_mem2reg = 1'b1; ID_RegWen = 1'b1; ID_wsel = wsel; IF_rs = 5'd8;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        nRST = 1'b0;
        idle_inputs();
        ihit = 1'b0;

        // Reset: RUN equations on the combinational outputs, counters clear
        #2;
        chk("rst_halted", 32'(halted), 1'b0);
        chk("rst_hc2", 32'(hit_check2), 1'b0);
        chk("rst_hc_noihit", 32'(hit_check), 1'b0);
        chk("rst_iren", 32'(iREN_en), 1'b1);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        chk("rst_wait_cnt", 32'(wait_cnt), 0);
        ihit = 1'b1;
        #1;
        chk("rst_hc_ihit", 32'(hit_check), 1'b1);
        chk("rst_pc_en", 32'(pc_en), 1'b1);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Load-use on rs
        load_use(5'd8);
        #1;
        chk("lu_stall", 32'(stall), 1'b1);
        chk("lu_pc_en", 32'(pc_en), 1'b0);
        chk("lu_flush", 32'(flush), 1'b0);
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 1);

        // Destination r0 never stalls
        load_use(5'd0);
        #1;
        chk("r0_stall", 32'(stall), 1'b0);
        chk("r0_pc_en", 32'(pc_en), 1'b1);
        tick();
        chk("r0_stall_cnt", 32'(stall_cnt), 1);

        // rt dependency only when the instruction reads rt
        idle_inputs();
        ID_mem2reg = 1'b1; ID_RegWen = 1'b1; ID_wsel = 5'd9; IF_rs = 5'd3; IF_rt = 5'd9;
        #1;
        chk("rt_unused_stall", 32'(stall), 1'b0);
        IF_uses_rt = 1'b1;
        #1;
        chk("rt_used_stall", 32'(stall), 1'b1);
        ID_RegWen = 1'b0;
        #1;
        chk("rt_nowen_stall", 32'(stall), 1'b0);
        ID_RegWen = 1'b1;
        tick();
        chk("rt_stall_cnt", 32'(stall_cnt), 2);

        // Flush beats stall
        idle_inputs();
        load_use(5'd8);
        EX_flush_req = 1'b1;
        #1;
        chk("fl_flush", 32'(flush), 1'b1);
        chk("fl_stall", 32'(stall), 1'b0);
        chk("fl_pc_en", 32'(pc_en), 1'b1);
        tick();
        chk("fl_flush_cnt", 32'(flush_cnt), 1);
        chk("fl_stall_cnt", 32'(stall_cnt), 2);

        // Flush request held while not advancing is ignored
        idle_inputs();
        ihit = 1'b0;
        EX_flush_req = 1'b1;
        #1;
        chk("flw_flush", 32'(flush), 1'b0);
        chk("flw_pc_en", 32'(pc_en), 1'b0);
        tick();
        chk("flw_flush_cnt", 32'(flush_cnt), 1);
        chk("flw_wait_cnt", 32'(wait_cnt), 1);

        // Data wait: three dhit-less cycles, then dhit
        idle_inputs();
        MEM_dREN = 1'b1;
        #1;
        chk("dw0_hc", 32'(hit_check), 1'b0);
        chk("dw0_iren", 32'(iREN_en), 1'b0);
        tick();
        #1;
        chk("dw1_hc", 32'(hit_check), 1'b0);
        chk("dw1_iren", 32'(iREN_en), 1'b0);
        tick();
        MEM_dREN = 1'b0;
        #1;
        chk("dw2_state_hc", 32'(hit_check), 1'b0);
        chk("dw2_state_iren", 32'(iREN_en), 1'b0);
        MEM_dREN = 1'b1;
        tick();
        chk("dw_wait_cnt", 32'(wait_cnt), 4);
        dhit = 1'b1;
        #1;
        chk("dw_hit_hc", 32'(hit_check), 1'b1);
        chk("dw_hit_pc_en", 32'(pc_en), 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("dw_back_run_iren", 32'(iREN_en), 1'b1);
        chk("dw_back_run_hc", 32'(hit_check), 1'b1);
        chk("dw_back_wait_cnt", 32'(wait_cnt), 4);

        // Asynchronous reset while in DWAIT
        MEM_dREN = 1'b1;
        tick();
        MEM_dREN = 1'b0;
        #1;
        chk("rdw_in_dwait", 32'(iREN_en), 1'b0);
        nRST = 1'b0;
        #1;
        chk("rdw_iren", 32'(iREN_en), 1'b1);
        chk("rdw_hc", 32'(hit_check), 1'b1);
        chk("rdw_stall_cnt", 32'(stall_cnt), 0);
        chk("rdw_flush_cnt", 32'(flush_cnt), 0);
        chk("rdw_wait_cnt", 32'(wait_cnt), 0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Halt: one advance, then frozen regardless of inputs
        MEM_halt = 1'b1;
        #1;
        chk("h_pre_halted", 32'(halted), 1'b0);
        chk("h_pre_pc_en", 32'(pc_en), 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("h_halted", 32'(halted), 1'b1);
        chk("h_hc2", 32'(hit_check2), 1'b1);
        chk("h_pc_en", 32'(pc_en), 1'b0);
        for (int i = 0; i < 10; i++) begin
            {ihit, dhit, IF_uses_rt, ID_mem2reg, ID_RegWen, EX_flush_req,
             MEM_dREN, MEM_dWEN, MEM_halt} = 9'($urandom);
            IF_rs = 5'($urandom); IF_rt = 5'($urandom); ID_wsel = 5'($urandom);
            #1;
            chk("hr_halted", 32'(halted), 1'b1);
            chk("hr_pc_en", 32'(pc_en), 1'b0);
            chk("hr_hc", 32'(hit_check), 1'b0);
            chk("hr_flush", 32'(flush), 1'b0);
            tick();
        end
        chk("h_wait_cnt", 32'(wait_cnt), 0);
        chk("h_stall_cnt", 32'(stall_cnt), 0);
        chk("h_flush_cnt", 32'(flush_cnt), 0);

        // Saturation of the stall counter
        nRST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        nRST = 1'b1;
        load_use(5'd8);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        chk("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        chk("sat_wait_cnt", 32'(wait_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
